// File: rtl/bridge_pkg.sv
// Shared constants and the transmitter state type for the bus-to-UART bridge.
package bridge_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT    = 434;  // 50 MHz / 115200 baud
  localparam int unsigned DEFAULT_DATA_WIDTH      = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH_LOG2 = 2;
  localparam int unsigned DEFAULT_FIFO_DEPTH      = 1 << DEFAULT_FIFO_DEPTH_LOG2;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with explicit occupancy count; a push into a full FIFO
// is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]  CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bus_uart_tx_bridge.sv
// Bus-slave write sink: buffers bytes in a FIFO and serialises them as 8N1
// UART frames; echoes the last written byte and drives the slave handshake.
module bus_uart_tx_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH_LOG2 = DEFAULT_FIFO_DEPTH_LOG2,
  parameter int unsigned CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_req,
  output logic                       module_dv,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       uart_tx,
  output logic                       tx_busy,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned       BIT_W     = $clog2(DATA_WIDTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  tx_state_e             state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  dv_q, dv_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  overflow_q, overflow_d;

  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic                  baud_tick;

  sync_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (wr_en),
    .pop_i   (fifo_pop),
    .wdata_i (wr_data),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign baud_tick = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          tx_d     = 1'b0;
          baud_d   = '0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          baud_d  = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      TX_DATA: begin
        if (baud_tick) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            // Line is driven from shift_q[1] so the next bit appears on this edge.
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + BIT_ONE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      TX_STOP: begin
        if (baud_tick) begin
          baud_d  = '0;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = TX_IDLE;
      end
    endcase
  end

  always_comb begin
    dv_d      = wr_en | rd_req;
    rd_data_d = wr_en ? wr_data : rd_data_q;
    // A drop flags overflow even when cleared in the same cycle.
    if (wr_en && fifo_full && !fifo_pop) overflow_d = 1'b1;
    else if (clr_overflow)               overflow_d = 1'b0;
    else                                 overflow_d = overflow_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= TX_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      dv_q       <= 1'b0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      dv_q       <= dv_d;
      rd_data_q  <= rd_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign uart_tx   = tx_q;
  assign module_dv = dv_q;
  assign rd_data   = rd_data_q;
  assign overflow  = overflow_q;
  assign tx_busy   = (state_q != TX_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_bus_uart_tx_bridge.sv
// Directed bench for bus_uart_tx_bridge with a 4-clock bit period.
module tb_bus_uart_tx_bridge;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_req = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       module_dv;
  logic [7:0] rd_data;
  logic       uart_tx;
  logic       tx_busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int fails  = 0;

  bus_uart_tx_bridge #(
    .DATA_WIDTH      (8),
    .FIFO_DEPTH_LOG2 (2),
    .CLKS_PER_BIT    (CPB)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_req       (rd_req),
    .module_dv    (module_dv),
    .rd_data      (rd_data),
    .uart_tx      (uart_tx),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic       exp_dv;
    logic [7:0] exp_rd;
    logic [2:0] exp_cnt;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en        = w;
    wr_data      = d;
    rd_req       = r;
    clr_overflow = c;
  endtask

  // Called just after the edge at offset first_j of a frame (0 = start edge);
  // returns just after the edge that begins the single idle cycle.
  task automatic check_frame(input logic [7:0] b, input int first_j);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int j = first_j; j < int'(FRAME); j++) begin
      chk($sformatf("frame %02h cyc %0d line", b, j), {31'd0, uart_tx}, {31'd0, fr[j / CPB]});
      chk($sformatf("frame %02h cyc %0d busy", b, j), {31'd0, tx_busy}, 32'd1);
      tick();
    end
    chk($sformatf("frame %02h idle gap", b), {31'd0, uart_tx}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 8'h10, 3'd1, 1'b0};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 3'd2, 1'b0};
    vecs[2]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 8'h12, 3'd3, 1'b0};
    vecs[3]  = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 8'h13, 3'd4, 1'b0};
    vecs[4]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 8'h14, 3'd4, 1'b1};
    vecs[5]  = '{1'b1, 8'h15, 1'b0, 1'b0, 1'b1, 8'h15, 3'd4, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h15, 3'd4, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h15, 3'd4, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h15, 3'd4, 1'b0};
    vecs[9]  = '{1'b1, 8'h16, 1'b0, 1'b1, 1'b1, 8'h16, 3'd4, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h16, 3'd4, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h16, 3'd4, 1'b0};

    // Reset state
    repeat (3) tick();
    chk("rst module_dv", {31'd0, module_dv}, 32'd0);
    chk("rst rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst tx_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("rst overflow", {31'd0, overflow}, 32'd0);
    #3 rstn = 1'b1;
    tick();

    // Read request with no prior write
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rd_req dv", {31'd0, module_dv}, 32'd1);
    chk("rd_req rd_data", {24'd0, rd_data}, 32'd0);
    chk("rd_req count", {29'd0, fifo_count}, 32'd0);
    chk("rd_req busy", {31'd0, tx_busy}, 32'd0);
    tick();
    chk("rd_req dv low", {31'd0, module_dv}, 32'd0);
    chk("rd_req line", {31'd0, uart_tx}, 32'd1);

    // Single byte 0x5A
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("5A dv", {31'd0, module_dv}, 32'd1);
    chk("5A rd_data", {24'd0, rd_data}, 32'h5A);
    chk("5A count", {29'd0, fifo_count}, 32'd1);
    chk("5A line pre-start", {31'd0, uart_tx}, 32'd1);
    tick();
    chk("5A dv low", {31'd0, module_dv}, 32'd0);
    chk("5A count popped", {29'd0, fifo_count}, 32'd0);
    check_frame(8'h5A, 0);
    chk("5A busy after stop", {31'd0, tx_busy}, 32'd0);

    // Five writes on consecutive cycles while idle
    drive(1'b1, 8'h01, 1'b0, 1'b0); tick();
    chk("w01 count", {29'd0, fifo_count}, 32'd1);
    drive(1'b1, 8'h02, 1'b0, 1'b0); tick();
    chk("w02 count", {29'd0, fifo_count}, 32'd1);
    chk("w02 start", {31'd0, uart_tx}, 32'd0);
    drive(1'b1, 8'h03, 1'b0, 1'b0); tick();
    chk("w03 count", {29'd0, fifo_count}, 32'd2);
    drive(1'b1, 8'h04, 1'b0, 1'b0); tick();
    chk("w04 count", {29'd0, fifo_count}, 32'd3);
    drive(1'b1, 8'h05, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("w05 count", {29'd0, fifo_count}, 32'd4);
    chk("w05 overflow", {31'd0, overflow}, 32'd0);
    chk("w05 rd_data", {24'd0, rd_data}, 32'h05);
    check_frame(8'h01, 3);
    for (int unsigned k = 2; k <= 5; k++) begin
      tick();
      check_frame(8'(k), 0);
    end
    chk("burst busy end", {31'd0, tx_busy}, 32'd0);

    // Overflow while a frame is in flight, then push coinciding with pop
    drive(1'b1, 8'hEE, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    for (int unsigned i = 0; i < 12; i++) begin
      drive(vecs[i].wr, vecs[i].data, vecs[i].rd, vecs[i].clr);
      tick();
      chk($sformatf("vec%0d dv", i), {31'd0, module_dv}, {31'd0, vecs[i].exp_dv});
      chk($sformatf("vec%0d rd_data", i), {24'd0, rd_data}, {24'd0, vecs[i].exp_rd});
      chk($sformatf("vec%0d count", i), {29'd0, fifo_count}, {29'd0, vecs[i].exp_cnt});
      chk($sformatf("vec%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      chk($sformatf("vec%0d busy", i), {31'd0, tx_busy}, 32'd1);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (FRAME - 12) tick();
    chk("full idle line", {31'd0, uart_tx}, 32'd1);
    chk("full idle count", {29'd0, fifo_count}, 32'd4);
    drive(1'b1, 8'h20, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("push+pop count", {29'd0, fifo_count}, 32'd4);
    chk("push+pop overflow", {31'd0, overflow}, 32'd0);
    chk("push+pop dv", {31'd0, module_dv}, 32'd1);
    chk("push+pop rd_data", {24'd0, rd_data}, 32'h20);
    check_frame(8'h10, 0);
    tick(); check_frame(8'h11, 0);
    tick(); check_frame(8'h12, 0);
    tick(); check_frame(8'h13, 0);
    tick(); check_frame(8'h20, 0);
    chk("drain busy", {31'd0, tx_busy}, 32'd0);
    chk("drain count", {29'd0, fifo_count}, 32'd0);

    // Asynchronous reset during data bit 3 of 0xA5 with 0x77 queued
    drive(1'b1, 8'hA5, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h77, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (17) tick();
    chk("A5 bit3 before reset", {31'd0, uart_tx}, 32'd0);
    chk("A5 queued count", {29'd0, fifo_count}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid-frame rst line", {31'd0, uart_tx}, 32'd1);
    chk("mid-frame rst count", {29'd0, fifo_count}, 32'd0);
    chk("mid-frame rst busy", {31'd0, tx_busy}, 32'd0);
    chk("mid-frame rst rd_data", {24'd0, rd_data}, 32'd0);
    chk("mid-frame rst overflow", {31'd0, overflow}, 32'd0);
    tick(); tick();
    #3 rstn = 1'b1;
    tick();
    for (int i = 0; i < 50; i++) begin
      chk($sformatf("post-rst quiet %0d", i), {30'd0, tx_busy, uart_tx}, 32'd1);
      tick();
    end
    drive(1'b1, 8'h3C, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    check_frame(8'h3C, 0);
    chk("3C busy end", {31'd0, tx_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
